// File: rtl/shiftreg_pkg.sv
// Shared types and constants for the serial shift-register blocks
// (this shift-out block and the companion shift-in block).
package shiftreg_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic FILL_DEFAULT = 1'b0;

endpackage

// File: rtl/shiftreg_out_ser.sv
// Parallel-in / serial-out shift register with load handshake,
// bit counter, per-word bit order and gapless back-to-back streaming.
module shiftreg_out_ser
   import shiftreg_pkg::*;
#(
   parameter int   WIDTH = 16,
   parameter logic FILL  = FILL_DEFAULT,
   parameter int   CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             lsb_first,
   input  logic             shift_en,
   output logic             shiftout,
   output logic             frame,
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic             dir;
   logic             dir_n;
   logic             done_n;
   logic             cnt_zero;
   logic             accept;
   logic             retire;

   assign cnt_zero   = (cnt == '0);
   assign retire     = (state == SHIFT) && shift_en;
   // A new word may land on the same edge that retires the last bit.
   assign load_ready = !sset && ((state == IDLE) || (cnt_zero && shift_en));
   assign accept     = load_valid && load_ready;
   assign shiftout   = dir ? q[0] : q[WIDTH-1];
   assign frame      = (state == SHIFT);

   always_comb begin
      state_n = state;
      q_n     = q;
      cnt_n   = cnt;
      dir_n   = dir;
      done_n  = 1'b0;
      if (sset) begin
         state_n = IDLE;
         q_n     = '1;
         cnt_n   = '0;
      end else begin
         if (retire && cnt_zero) begin
            done_n = 1'b1;
         end
         if (accept) begin
            state_n = SHIFT;
            q_n     = load_data;
            dir_n   = lsb_first;
            cnt_n   = CNT_LAST;
         end else if (retire) begin
            if (dir) begin
               q_n = {FILL, q[WIDTH-1:1]};
            end else begin
               q_n = {q[WIDTH-2:0], FILL};
            end
            if (cnt_zero) begin
               state_n = IDLE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         q     <= '0;
         cnt   <= '0;
         dir   <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         q     <= q_n;
         cnt   <= cnt_n;
         dir   <= dir_n;
         done  <= done_n;
      end
   end

endmodule

// File: tb/tb_shiftreg_out_ser.sv
// Scoreboard bench for shiftreg_out_ser: directed WIDTH=16 scenarios
// plus a WIDTH=2/7/32 sweep running alongside on the same clock.
module tb_shiftreg_out_ser;

   logic        clk;
   logic        reset;
   logic        sset;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic        lsb_first;
   logic        shift_en;
   logic        shiftout;
   logic        frame;
   logic        done;

   int tests = 0;
   int fails = 0;

   logic exp_q[$];
   logic exp_bit;
   int   exp_done  = 0;
   int   got_done  = 0;
   int   frame_cyc = 0;
   int   frame_fall = 0;
   int   acc_cnt   = 0;
   logic frame_q   = 1'b0;

   shiftreg_out_ser #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset), .sset(sset),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .lsb_first(lsb_first),
      .shift_en(shift_en), .shiftout(shiftout),
      .frame(frame), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] d, input logic lsb);
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(lsb ? d[i] : d[15-i]);
      end
      exp_done++;
   endtask

   task automatic load_word(input string nm, input logic [15:0] d,
                            input logic lsb);
      bit ok;
      ok = 1'b0;
      load_data  = d;
      lsb_first  = lsb;
      load_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (load_ready) begin
            ok = 1'b1;
            push_word(d, lsb);
         end
         step();
      end
      load_valid = 1'b0;
      chk({nm, "_accepted"}, ok, 1'b1);
   endtask

   task automatic wait_done(input string nm, input int max);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk({nm, "_done_seen"}, seen, 1'b1);
   endtask

   // Main scoreboard monitor: a bit is retired on every edge with frame && shift_en.
   always @(negedge clk) begin
      if (!reset) begin
         if (frame) frame_cyc++;
         if (frame_q && !frame) frame_fall++;
         frame_q = frame;
         if (load_valid && load_ready) acc_cnt++;
         if (done) got_done++;
         if (frame && shift_en) begin
            chk("main_bit_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               exp_bit = exp_q.pop_front();
               chk("main_bit", shiftout, exp_bit);
            end
         end
      end
   end

   for (genvar g = 0; g < 3; g++) begin : sw
      localparam int W = (g == 0) ? 2 : (g == 1) ? 7 : 32;
      logic         rst;
      logic         ss;
      logic         lv;
      logic         lr;
      logic [W-1:0] ld;
      logic         lsb;
      logic         se;
      logic         so;
      logic         fr;
      logic         dn;
      logic         eq[$];
      logic         eb;
      int           exp_d = 0;
      int           got_d = 0;
      bit           fin = 1'b0;

      shiftreg_out_ser #(.WIDTH(W)) u (
         .clk(clk), .reset(rst), .sset(ss),
         .load_valid(lv), .load_ready(lr),
         .load_data(ld), .lsb_first(lsb),
         .shift_en(se), .shiftout(so),
         .frame(fr), .done(dn)
      );

      task automatic push(input logic [W-1:0] d, input logic l);
         for (int i = 0; i < W; i++) begin
            eq.push_back(l ? d[i] : d[W-1-i]);
         end
         exp_d++;
      endtask

      always @(negedge clk) begin
         if (!rst) begin
            if (dn) got_d++;
            if (fr && se) begin
               chk($sformatf("w%0d_bit_expected", W), eq.size() != 0, 1'b1);
               if (eq.size() != 0) begin
                  eb = eq.pop_front();
                  chk($sformatf("w%0d_bit", W), so, eb);
               end
            end
         end
      end

      initial begin : stim
         int  n;
         int  cyc;
         bit  acc;
         n   = 0;
         cyc = 0;
         rst = 1'b1;
         ss  = 1'b0;
         lv  = 1'b0;
         ld  = '0;
         lsb = 1'b0;
         se  = 1'b0;
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
         while (cyc < 3000 && (n < 6 || eq.size() != 0 || fr)) begin
            se = ($urandom_range(0, 3) != 0);
            if (!lv && n < 6) begin
               ld  = W'($urandom);
               lsb = 1'($urandom_range(0, 1));
               lv  = 1'b1;
            end
            acc = 1'b0;
            @(negedge clk);
            if (lv && lr) begin
               push(ld, lsb);
               n++;
               acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) lv = 1'b0;
            cyc++;
         end
         chk($sformatf("w%0d_in_time", W), cyc < 3000, 1'b1);
         se = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         chk($sformatf("w%0d_done_count", W), got_d, exp_d);
         chk($sformatf("w%0d_words", W), n, 6);
         chk($sformatf("w%0d_queue_empty", W), eq.size(), 0);
         fin = 1'b1;
      end
   end

   initial begin : main
      int  f0, d0, a0, ff0;
      bit  all_fin;
      reset      = 1'b1;
      sset       = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      lsb_first  = 1'b0;
      shift_en   = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_shiftout", shiftout, 1'b0);
      chk("rst_frame", frame, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_load_ready", load_ready, 1'b1);
      step();

      // Single word, MSB first
      shift_en = 1'b1;
      f0 = frame_cyc;
      d0 = got_done;
      load_word("t1", 16'hA5C3, 1'b0);
      wait_done("t1", 40);
      chk("t1_frame_at_done", frame, 1'b0);
      chk("t1_out_fill", shiftout, 1'b0);
      step();
      chk("t1_frame_cycles", frame_cyc - f0, 16);
      chk("t1_done_pulses", got_done - d0, 1);
      chk("t1_queue_empty", exp_q.size(), 0);

      // LSB first, one enable every 4th cycle
      shift_en = 1'b0;
      f0 = frame_cyc;
      d0 = got_done;
      load_word("t2", 16'h0001, 1'b1);
      for (int c = 0; c < 64; c++) begin
         shift_en = (c % 4 == 3);
         @(negedge clk);
         if (c < 4) chk("t2_first_bit_held", shiftout, 1'b1);
         if (c == 4) chk("t2_second_bit", shiftout, 1'b0);
         if (c == 62) chk("t2_no_early_done", done, 1'b0);
         step();
      end
      shift_en = 1'b0;
      @(negedge clk);
      chk("t2_done", done, 1'b1);
      chk("t2_frame_at_done", frame, 1'b0);
      step();
      chk("t2_frame_cycles", frame_cyc - f0, 64);
      chk("t2_done_pulses", got_done - d0, 1);

      // Back-to-back streaming with load_valid held
      shift_en = 1'b1;
      f0  = frame_cyc;
      d0  = got_done;
      a0  = acc_cnt;
      ff0 = frame_fall;
      load_word("t3a", 16'hFFFF, 1'b0);
      load_word("t3b", 16'h0000, 1'b0);
      wait_done("t3_first", 40);
      chk("t3_frame_kept", frame, 1'b1);
      wait_done("t3_second", 40);
      step();
      chk("t3_frame_cycles", frame_cyc - f0, 32);
      chk("t3_frame_falls", frame_fall - ff0, 1);
      chk("t3_done_pulses", got_done - d0, 2);
      chk("t3_accepts", acc_cnt - a0, 2);

      // sset mid-frame
      d0 = got_done;
      load_word("t4", 16'h1234, 1'b0);
      repeat (5) @(posedge clk);
      #1 sset = 1'b1;
      @(negedge clk);
      chk("t4_ready_in_sset", load_ready, 1'b0);
      step();
      sset = 1'b0;
      exp_q.delete();
      exp_done--;
      @(negedge clk);
      chk("t4_shiftout_ones", shiftout, 1'b1);
      chk("t4_frame", frame, 1'b0);
      chk("t4_ready_after", load_ready, 1'b1);
      chk("t4_no_done", done, 1'b0);
      repeat (3) step();
      chk("t4_done_pulses", got_done - d0, 0);

      // reset wins over sset mid-frame
      d0 = got_done;
      load_word("t5", 16'hFFFF, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      sset  = 1'b1;
      step();
      reset = 1'b0;
      sset  = 1'b0;
      exp_q.delete();
      exp_done--;
      @(negedge clk);
      chk("t5_shiftout", shiftout, 1'b0);
      chk("t5_frame", frame, 1'b0);
      chk("t5_done", done, 1'b0);
      chk("t5_q_zero", dut.q, 16'h0000);
      repeat (3) step();
      chk("t5_done_pulses", got_done - d0, 0);

      all_fin = 1'b0;
      for (int i = 0; i < 5000 && !all_fin; i++) begin
         @(posedge clk);
         all_fin = sw[0].fin && sw[1].fin && sw[2].fin;
      end
      chk("sweep_finished", all_fin, 1'b1);
      chk("main_queue_empty", exp_q.size(), 0);
      chk("main_done_total", got_done, exp_done);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
